// File: rtl/anim_bird_sprite_if.sv
// Pixel/ROM render bus between the bird sprite, its sprite ROM and the VGA mixer.
// The master side drives the scan position and ROM data; the slave (sprite) returns address and pixel.
interface anim_bird_sprite_if #(
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int ROM_AW = 13
);
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [ROM_AW-1:0] rom_addr;
  logic [11:0]       rom_data;
  logic              valid;
  logic [11:0]       color;

  modport master (output x, y, rom_data, input rom_addr, valid, color);
  modport slave  (input x, y, rom_data, output rom_addr, valid, color);
endinterface

// File: rtl/anim_bird_sprite.sv
// Animated bird sprite: sub-pixel gravity physics, N-frame wing animation, 2-cycle ROM render pipe.
// Optional BIRD_NO_FALL_EN adds a no_fall input that freezes y/vel while flying (debug hover).
module anim_bird_sprite #(
  parameter int          X_W        = 10,
  parameter int          Y_W        = 10,
  parameter int          BIRD_X     = 0,
  parameter int          Y_INIT     = 240,
  parameter int          BIRD_W     = 40,
  parameter int          BIRD_H     = 45,
  parameter int          SCREEN_H   = 480,
  parameter int          FRAC_W     = 4,
  parameter int          VEL_W      = 8,
  parameter int          GRAVITY    = 6,
  parameter int          FLAP_VEL   = -48,
  parameter int          VMAX       = 96,
  parameter int          N_FRAMES   = 3,
  parameter int          ANIM_TICKS = 6,
  parameter logic [11:0] KEY_COLOR  = 12'h0F0,
  parameter int          ROM_AW     = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 run,
  input  logic                 flap,
  input  logic                 hit,
`ifdef BIRD_NO_FALL_EN
  input  logic                 no_fall,
`endif
  anim_bird_sprite_if.slave    pix,
  output logic                 out_of_bound,
  output logic [Y_W-1:0]       y_pos,
  output logic [1:0]           bstate
);
  localparam int YW = Y_W + FRAC_W + 1;
  localparam int FW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
  localparam int AW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;

  localparam logic signed [YW-1:0]    YInit     = YW'(Y_INIT * (2 ** FRAC_W));
  localparam logic signed [YW-1:0]    YGround   = YW'((SCREEN_H - BIRD_H) * (2 ** FRAC_W));
  localparam logic signed [VEL_W-1:0] VFlap     = VEL_W'(FLAP_VEL);
  localparam logic signed [VEL_W-1:0] VMax      = VEL_W'(VMAX);
  localparam logic signed [VEL_W:0]   VMaxW     = (VEL_W + 1)'(VMAX);
  localparam logic signed [VEL_W:0]   VGrav     = (VEL_W + 1)'(GRAVITY);
  localparam logic [FW-1:0]           FrameLast = FW'(N_FRAMES - 1);
  localparam logic [AW-1:0]           AnimLast  = AW'(ANIM_TICKS - 1);

  typedef enum logic [1:0] {
    StReady    = 2'd0,
    StFly      = 2'd1,
    StFalling  = 2'd2,
    StGrounded = 2'd3
  } state_e;

  state_e                   state_q;
  logic signed [YW-1:0]     y_q;
  logic signed [VEL_W-1:0]  vel_q;
  logic [FW-1:0]            frame_q;
  logic [AW-1:0]            anim_cnt_q;
  logic                     flap_pend_q;
  logic                     inbox_q;

  logic signed [YW-1:0]     y_sum, y_tick;
  logic signed [VEL_W:0]    vel_wide;
  logic signed [VEL_W-1:0]  vel_grav;
  logic                     ground, hover, anim_en;
  int                       dx, dy, addr_full;
  logic                     inbox;

  assign y_pos  = y_q[Y_W+FRAC_W-1:FRAC_W];
  assign bstate = state_q;

`ifdef BIRD_NO_FALL_EN
  assign hover = no_fall && (state_q == StFly);
`else
  assign hover = 1'b0;
`endif

  always_comb begin
    y_sum    = y_q + YW'(vel_q);
    y_tick   = y_sum[YW-1] ? '0 : y_sum;
    // y_tick is never negative, so comparing sub-pixel values equals comparing integer rows
    ground   = (y_tick >= YGround);
    vel_wide = $signed({vel_q[VEL_W-1], vel_q}) + VGrav;
    vel_grav = (vel_wide > VMaxW) ? VMax : vel_wide[VEL_W-1:0];
    anim_en  = tick && (!run || state_q == StReady || state_q == StFly);
  end

  always_comb begin
    dx        = 32'(pix.x) - BIRD_X;
    dy        = 32'(pix.y) - 32'(y_pos);
    inbox     = (dx >= 0) && (dx < BIRD_W) && (dy >= 0) && (dy < BIRD_H);
    addr_full = 32'(frame_q) * BIRD_W * BIRD_H + dx + dy * BIRD_W;
    pix.rom_addr = inbox ? addr_full[ROM_AW-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReady;
      y_q          <= YInit;
      vel_q        <= '0;
      frame_q      <= '0;
      anim_cnt_q   <= '0;
      flap_pend_q  <= 1'b0;
      out_of_bound <= 1'b0;
      inbox_q      <= 1'b0;
      pix.valid    <= 1'b0;
      pix.color    <= '0;
    end else begin
      if (anim_en) begin
        if (anim_cnt_q == AnimLast) begin
          anim_cnt_q <= '0;
          frame_q    <= (frame_q == FrameLast) ? '0 : frame_q + 1'b1;
        end else begin
          anim_cnt_q <= anim_cnt_q + 1'b1;
        end
      end

      // A pending flap survives only while flying and is consumed by the next tick
      flap_pend_q <= run && (state_q == StFly) && !hover && (flap || (flap_pend_q && !tick));

      if (!run) begin
        state_q      <= StReady;
        y_q          <= YInit;
        vel_q        <= '0;
        out_of_bound <= 1'b0;
      end else begin
        unique case (state_q)
          StReady: if (tick) state_q <= StFly;
          StFly, StFalling: begin
            if (tick && !hover) begin
              vel_q <= (state_q == StFly && flap_pend_q && !hit) ? VFlap : vel_grav;
              if (ground) begin
                y_q          <= YGround;
                out_of_bound <= 1'b1;
                state_q      <= StGrounded;
              end else begin
                y_q <= y_tick;
                if (hit) state_q <= StFalling;
              end
            end else if (hit) begin
              state_q <= StFalling;
            end
          end
          default: ;
        endcase
      end

      inbox_q   <= inbox;
      pix.valid <= inbox_q && (pix.rom_data != KEY_COLOR);
      pix.color <= (inbox_q && (pix.rom_data != KEY_COLOR)) ? pix.rom_data : '0;
    end
  end
endmodule

// File: tb/tb_anim_bird_sprite.sv
// Randomised bench for anim_bird_sprite against a cycle-level behavioural model.
module tb_anim_bird_sprite;
  localparam logic [11:0] KEY = 12'h0F0;

  logic       clk = 1'b0;
  logic       rst, tick, run, flap, hit;
  logic       out_of_bound;
  logic [9:0] y_pos;
  logic [1:0] bstate;
`ifdef BIRD_NO_FALL_EN
  logic       no_fall = 1'b0;
`endif

  anim_bird_sprite_if #(.X_W(10), .Y_W(10), .ROM_AW(13)) bus ();

  anim_bird_sprite dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .run          (run),
    .flap         (flap),
    .hit          (hit),
`ifdef BIRD_NO_FALL_EN
    .no_fall      (no_fall),
`endif
    .pix          (bus),
    .out_of_bound (out_of_bound),
    .y_pos        (y_pos),
    .bstate       (bstate)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input int a);
    logic [11:0] v;
    if (a % 5 == 3) return KEY;
    v = 12'(a * 37 + 11);
    if (v == KEY) v = 12'h0F1;
    return v;
  endfunction

  // Synchronous sprite ROM
  always @(posedge clk) bus.rom_data <= rom_fn(int'(bus.rom_addr));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: y in sub-pixels, vel in sub-pixels/tick, state 0..3
  int m_st, m_y, m_vel, m_oob, m_frame, m_cnt, m_pend;
  int m_inbox1, m_addr1, m_valid, m_color;

  task automatic model_reset();
    m_st = 0; m_y = 240 * 16; m_vel = 0; m_oob = 0; m_frame = 0; m_cnt = 0; m_pend = 0;
    m_inbox1 = 0; m_addr1 = 0; m_valid = 0; m_color = 0;
  endtask

  task automatic model_step(input bit tk, input bit rn, input bit fl, input bit ht);
    int st0, ny, nv, pend_next;
    st0 = m_st;
    if (tk && (!rn || st0 <= 1)) begin
      m_cnt++;
      if (m_cnt == 6) begin
        m_cnt   = 0;
        m_frame = (m_frame + 1) % 3;
      end
    end
    pend_next = (rn && st0 == 1 && (fl || (m_pend && !tk))) ? 1 : 0;
    if (!rn) begin
      m_st = 0; m_y = 240 * 16; m_vel = 0; m_oob = 0;
    end else if (st0 == 0) begin
      if (tk) m_st = 1;
    end else if (st0 == 1 || st0 == 2) begin
      if (tk) begin
        ny = m_y + m_vel;
        if (ny < 0) ny = 0;
        nv = m_vel + 6;
        if (nv > 96) nv = 96;
        if (st0 == 1 && m_pend && !ht) nv = -48;
        m_vel = nv;
        if (ny / 16 >= 435) begin
          m_y = 435 * 16; m_oob = 1; m_st = 3;
        end else begin
          m_y = ny;
          if (ht) m_st = 2;
        end
      end else if (ht) begin
        m_st = 2;
      end
    end
    m_pend = pend_next;
  endtask

  // One clock: drive at the falling edge, check, advance the model, wait for the next falling edge
  task automatic cycle(input bit tk, input bit rn, input bit fl, input bit ht, input int px,
                       input int py);
    int  ypos, dy, addr;
    bit  inbox;
    tick = tk; run = rn; flap = fl; hit = ht;
    bus.x = 10'(px);
    bus.y = 10'(py);
    #1;
    ypos  = m_y / 16;
    dy    = py - ypos;
    inbox = (px < 40) && (dy >= 0) && (dy < 45);
    addr  = inbox ? m_frame * 1800 + px + dy * 40 : 0;
    check("rom_addr", int'(bus.rom_addr), addr);
    check("y_pos", int'(y_pos), ypos);
    check("bstate", int'(bstate), m_st);
    check("out_of_bound", int'(out_of_bound), m_oob);
    check("valid", int'(bus.valid), m_valid);
    check("color", int'(bus.color), m_color);
    m_valid  = (m_inbox1 && rom_fn(m_addr1) != KEY) ? 1 : 0;
    m_color  = m_valid ? int'(rom_fn(m_addr1)) : 0;
    m_inbox1 = inbox;
    m_addr1  = addr;
    model_step(tk, rn, fl, ht);
    @(negedge clk);
  endtask

  // Random scan position, mostly around the bird
  task automatic rcycle(input bit tk, input bit rn, input bit fl, input bit ht);
    int py;
    py = m_y / 16 + int'($urandom_range(0, 55)) - 5;
    if (py < 0) py = 0;
    cycle(tk, rn, fl, ht, int'($urandom_range(0, 50)), py);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; run = 1'b0; flap = 1'b0; hit = 1'b0;
    bus.x = 10'd1000; bus.y = 10'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    do_reset();

    // Idle animation with run low
    for (int t = 0; t < 18; t++) begin
      rcycle(1'b1, 1'b0, 1'b0, 1'b0);
      rcycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (t == 5) begin
        bus.x = 10'd5; bus.y = 10'd242; tick = 1'b0;
        #1;
        check("frame1_addr", int'(bus.rom_addr), 1885);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 5, 242);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 5, 242);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 5, 242);
      end
    end
    check("idle_ypos", int'(y_pos), 240);

    // Start flying, then ten gravity ticks
    rcycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("fly_state", int'(bstate), 1);
    for (int t = 0; t < 10; t++) begin
      rcycle(1'b1, 1'b1, 1'b0, 1'b0);
      rcycle(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("gravity_ypos", int'(y_pos), 256);

    // Free fall to the ground
    for (int t = 0; t < 200 && bstate != 2'd3; t++) begin
      rcycle(1'b1, 1'b1, 1'b0, 1'b0);
      rcycle(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("ground_ypos", int'(y_pos), 435);
    check("ground_oob", int'(out_of_bound), 1);
    check("ground_state", int'(bstate), 3);
    for (int t = 0; t < 3; t++) rcycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("ground_hold", int'(y_pos), 435);
    rcycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("rerun_ypos", int'(y_pos), 240);
    check("rerun_state", int'(bstate), 0);
    check("rerun_oob", int'(out_of_bound), 0);

    // Flap and hit before the same tick
    rcycle(1'b1, 1'b1, 1'b0, 1'b0);
    rcycle(1'b1, 1'b1, 1'b0, 1'b0);
    rcycle(1'b0, 1'b1, 1'b1, 1'b0);
    rcycle(1'b0, 1'b1, 1'b0, 1'b1);
    rcycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("hit_state", int'(bstate), 2);

    // Random play
    for (int c = 0; c < 3000; c++) begin
      bit tk, rn, fl, ht;
      if (c == 1500) begin
        do_reset();
      end
      tk = (c % 4 == 0);
      rn = ($urandom_range(0, 63) != 0);
      fl = !tk && ($urandom_range(0, 5) == 0);
      ht = !tk && ($urandom_range(0, 79) == 0);
      rcycle(tk, rn, fl, ht);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
